// File: rtl/fam_edge_dispatcher_if.sv
// Edge stream input and four-lane edge output bus of the FAM edge dispatcher.
interface fam_edge_dispatcher_if #(
   parameter int ADDRW = 16,
   parameter int WL    = 32
);
   logic [ADDRW-1:0] in_src;
   logic [ADDRW-1:0] in_dst;
   logic [WL-1:0]    in_value;
   logic             in_valid;
   logic             in_ready;

   logic [ADDRW-1:0] src0, src1, src2, src3;
   logic [ADDRW-1:0] dst0, dst1, dst2, dst3;
   logic [WL-1:0]    value0, value1, value2, value3;
   logic             valid0, valid1, valid2, valid3;

   modport master (
      output in_src, in_dst, in_value, in_valid,
      input  in_ready,
      input  src0, src1, src2, src3, dst0, dst1, dst2, dst3,
      input  value0, value1, value2, value3, valid0, valid1, valid2, valid3
   );

   modport slave (
      input  in_src, in_dst, in_value, in_valid,
      output in_ready,
      output src0, src1, src2, src3, dst0, dst1, dst2, dst3,
      output value0, value1, value2, value3, valid0, valid1, valid2, valid3
   );
endinterface

// File: rtl/fam_edge_dispatcher.sv
// Packs single edges into groups of up to four and drives them onto the FAM
// edge lanes, sequencing one counted phase with timeout flush of partial groups.
module fam_edge_dispatcher #(
   parameter int ADDRW   = 16,
   parameter int WL      = 32,
   parameter int CNTW    = 24,
   parameter int TIMEOUT = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic                  start,
   input  logic [CNTW-1:0]       edge_count,
   output logic                  busy,
   output logic                  done,
   output logic [CNTW-1:0]       groups_sent,
   fam_edge_dispatcher_if.slave  bus
);
   localparam int WAITW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

   state_t           r_state;
   logic [CNTW-1:0]  r_remaining;
   logic [CNTW-1:0]  r_groups;
   logic [2:0]       r_fill;
   logic [WAITW-1:0] r_wait;
   logic             r_done;
   logic [3:0]       r_valid;
   logic [ADDRW-1:0] r_slot_src [4];
   logic [ADDRW-1:0] r_slot_dst [4];
   logic [WL-1:0]    r_slot_val [4];
   logic [ADDRW-1:0] r_lane_src [4];
   logic [ADDRW-1:0] r_lane_dst [4];
   logic [WL-1:0]    r_lane_val [4];

   logic       w_in_ready, w_accept, w_emit_full, w_emit_last, w_emit_tmo, w_emit;
   logic [2:0] w_fill_next;

   assign w_in_ready  = ena & (r_state == S_COLLECT) & (r_remaining != '0);
   assign w_accept    = bus.in_valid & w_in_ready;
   assign w_fill_next = r_fill + 3'(w_accept);
   assign w_emit_full = w_accept & (r_fill == 3'd3);
   assign w_emit_last = w_accept & (r_remaining == CNTW'(1));
   assign w_emit_tmo  = ena & (r_state == S_COLLECT) & ~w_accept & (r_fill != 3'd0)
                        & (r_wait == WAITW'(TIMEOUT));
   assign w_emit      = w_emit_full | w_emit_last | w_emit_tmo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_remaining <= '0;
         r_groups    <= '0;
         r_fill      <= '0;
         r_wait      <= '0;
         r_done      <= 1'b0;
         r_valid     <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            r_slot_src[i] <= '0;
            r_slot_dst[i] <= '0;
            r_slot_val[i] <= '0;
            r_lane_src[i] <= '0;
            r_lane_dst[i] <= '0;
            r_lane_val[i] <= '0;
         end
      end else begin
         r_valid <= '0;
         r_done  <= 1'b0;
         if (ena) begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_remaining <= edge_count;
                     r_groups    <= '0;
                     r_fill      <= '0;
                     r_wait      <= '0;
                     r_state     <= (edge_count == '0) ? S_DONE : S_COLLECT;
                  end
               end
               S_COLLECT: begin
                  if (w_accept) begin
                     r_slot_src[r_fill[1:0]] <= bus.in_src;
                     r_slot_dst[r_fill[1:0]] <= bus.in_dst;
                     r_slot_val[r_fill[1:0]] <= bus.in_value;
                     r_remaining             <= r_remaining - CNTW'(1);
                  end
                  if (w_emit) begin
                     // The edge accepted on the emitting edge bypasses the slots.
                     for (int unsigned i = 0; i < 4; i++) begin
                        if (w_accept && (3'(i) == r_fill)) begin
                           r_lane_src[i] <= bus.in_src;
                           r_lane_dst[i] <= bus.in_dst;
                           r_lane_val[i] <= bus.in_value;
                        end else begin
                           r_lane_src[i] <= r_slot_src[i];
                           r_lane_dst[i] <= r_slot_dst[i];
                           r_lane_val[i] <= r_slot_val[i];
                        end
                        r_valid[i] <= (3'(i) < w_fill_next);
                     end
                     r_fill   <= '0;
                     r_wait   <= '0;
                     r_groups <= r_groups + CNTW'(1);
                     if (w_emit_last) r_state <= S_DONE;
                  end else if (w_accept) begin
                     r_fill <= w_fill_next;
                     r_wait <= '0;
                  end else if (r_fill != 3'd0) begin
                     r_wait <= r_wait + WAITW'(1);
                  end
               end
               S_DONE: begin
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign busy         = (r_state != S_IDLE);
   assign done         = r_done;
   assign groups_sent  = r_groups;
   assign bus.in_ready = w_in_ready;

   assign bus.src0   = r_lane_src[0];
   assign bus.src1   = r_lane_src[1];
   assign bus.src2   = r_lane_src[2];
   assign bus.src3   = r_lane_src[3];
   assign bus.dst0   = r_lane_dst[0];
   assign bus.dst1   = r_lane_dst[1];
   assign bus.dst2   = r_lane_dst[2];
   assign bus.dst3   = r_lane_dst[3];
   assign bus.value0 = r_lane_val[0];
   assign bus.value1 = r_lane_val[1];
   assign bus.value2 = r_lane_val[2];
   assign bus.value3 = r_lane_val[3];
   assign bus.valid0 = r_valid[0];
   assign bus.valid1 = r_valid[1];
   assign bus.valid2 = r_valid[2];
   assign bus.valid3 = r_valid[3];
endmodule
